apuf_chal_sequencer: RTL and testbench

Consumer end of the PicoBlaze controller's challenge interface. It takes the 64-bit words and write strobes issued by the controller, assembles them into the full arbiter-PUF challenge, and fires the delay-chain trigger when the controller requests it. It then captures the arbiter response and hands it back to the controller through a ready/bit pair. It sits between puf_controller and the APUF delay chain in the deploy top level.

---
 rtl/apuf_pkg.sv | 19 +
 rtl/apuf_edge_det.sv | 25 ++
 rtl/apuf_chal_sequencer.sv | 146 ++++++++++++++
 tb/tb_apuf_chal_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apuf_pkg.sv
// Shared types and sizing for the arbiter-PUF challenge sequencer.
package apuf_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    FIRE = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned ID_W   = 2;

  function automatic int unsigned nseg_of(input int unsigned nchal);
    return nchal / WORD_W;
  endfunction

endpackage

// File: rtl/apuf_edge_det.sv
// Registers a level strobe and flags its rising edge for one cycle.
module apuf_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse_c
);

  logic prev;
  logic armed;

  // armed blocks a level already high at reset release from looking like a new edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= level;
      armed <= 1'b1;
    end
  end

  assign pulse_c = level & ~prev & armed;

endmodule

// File: rtl/apuf_chal_sequencer.sv
// Assembles the APUF challenge from controller writes, fires the delay-chain
// trigger and returns the captured arbiter response.
module apuf_chal_sequencer
  import apuf_pkg::*;
#(
  parameter int unsigned NCHAL       = 128,
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned TRIG_CYC    = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     chal_en,
  input  logic                     wr_en,
  input  logic [ID_W-1:0]          in_id,
  input  logic [WORD_W-1:0]        data_in,
  input  logic                     start,
  input  logic                     resp_valid_in,
  input  logic                     resp_bit_in,
  output logic [NCHAL-1:0]         challenge,
  output logic                     trig,
  output logic                     resp_ready,
  output logic                     resp_bit,
  output logic                     busy,
  output logic [NCHAL/WORD_W-1:0]  seg_loaded,
  output logic                     timeout_err
);

  localparam int unsigned NSEG    = nseg_of(NCHAL);
  localparam int unsigned MAX_ST  = (SETTLE_CYC > TRIG_CYC) ? SETTLE_CYC : TRIG_CYC;
  localparam int unsigned CNT_MAX = (MAX_ST > TIMEOUT_CYC) ? MAX_ST : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               wr_pulse_c;
  logic               start_pulse_c;
  logic [NCHAL-1:0]   chal_wr_c;
  logic [NSEG-1:0]    seg_wr_c;
  logic               start_ok_c;

  apuf_edge_det u_wr_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .level   (wr_en),
    .pulse_c (wr_pulse_c)
  );

  apuf_edge_det u_start_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .level   (start),
    .pulse_c (start_pulse_c)
  );

  // Write merge; only IDLE/DONE accept words so the chain sees a stable challenge.
  always_comb begin
    chal_wr_c = challenge;
    seg_wr_c  = seg_loaded;
    if (wr_pulse_c && (state == IDLE || state == DONE)) begin
      for (int k = 0; k < NSEG; k++) begin
        if (in_id == ID_W'(k)) begin
          chal_wr_c[(NSEG - k) * WORD_W - 1 -: WORD_W] = data_in;
          seg_wr_c[NSEG - 1 - k] = 1'b1;
        end
      end
    end
    start_ok_c = start_pulse_c && (&seg_wr_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      challenge   <= '0;
      seg_loaded  <= '0;
      trig        <= 1'b0;
      resp_ready  <= 1'b0;
      resp_bit    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else if (!chal_en) begin
      state      <= IDLE;
      cnt        <= '0;
      challenge  <= '0;
      seg_loaded <= '0;
      trig       <= 1'b0;
      resp_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      challenge  <= chal_wr_c;
      seg_loaded <= seg_wr_c;
      case (state)
        IDLE, DONE: begin
          if (start_ok_c) begin
            state       <= ARM;
            cnt         <= '0;
            busy        <= 1'b1;
            resp_ready  <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        ARM: begin
          if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
            state <= FIRE;
            trig  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIRE: begin
          if (cnt == CNT_W'(TRIG_CYC - 1)) begin
            state <= WAIT;
            trig  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          if (resp_valid_in) begin
            resp_bit   <= resp_bit_in;
            resp_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            resp_bit    <= 1'b0;
            resp_ready  <= 1'b1;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          trig  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apuf_chal_sequencer.sv
// Directed-plus-random bench for apuf_chal_sequencer against a word-level model.
module tb_apuf_chal_sequencer;

  localparam int unsigned NCHAL  = 128;
  localparam int unsigned WORD   = 64;
  localparam int unsigned NSEG   = NCHAL / WORD;
  localparam int unsigned SETTLE = 8;
  localparam int unsigned TRIGW  = 4;
  localparam int unsigned TMO    = 1024;

  logic              clk;
  logic              rst_n;
  logic              chal_en;
  logic              wr_en;
  logic [1:0]        in_id;
  logic [63:0]       data_in;
  logic              start;
  logic              resp_valid_in;
  logic              resp_bit_in;
  logic [NCHAL-1:0]  challenge;
  logic              trig;
  logic              resp_ready;
  logic              resp_bit;
  logic              busy;
  logic [NSEG-1:0]   seg_loaded;
  logic              timeout_err;

  int n_cmp;
  int n_err;

  logic [63:0] words  [NSEG];
  bit          loaded [NSEG];

  apuf_chal_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .chal_en       (chal_en),
    .wr_en         (wr_en),
    .in_id         (in_id),
    .data_in       (data_in),
    .start         (start),
    .resp_valid_in (resp_valid_in),
    .resp_bit_in   (resp_bit_in),
    .challenge     (challenge),
    .trig          (trig),
    .resp_ready    (resp_ready),
    .resp_bit      (resp_bit),
    .busy          (busy),
    .seg_loaded    (seg_loaded),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // id 0 is the most-significant word: shift words in from id 0 upward
  function automatic logic [NCHAL-1:0] exp_chal();
    logic [NCHAL-1:0] r;
    r = '0;
    for (int k = 0; k < NSEG; k++) r = (r << WORD) | NCHAL'(words[k]);
    return r;
  endfunction

  function automatic logic [NSEG-1:0] exp_seg();
    logic [NSEG-1:0] s;
    s = '0;
    for (int k = 0; k < NSEG; k++) s = (s << 1) | NSEG'(loaded[k]);
    return s;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < NSEG; k++) begin
      words[k]  = '0;
      loaded[k] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [NCHAL-1:0] obs, input logic [NCHAL-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] id, input logic [63:0] d);
    wr_en = 1'b1; in_id = id; data_in = d;
    step();
    wr_en = 1'b0;
    step();
    if (int'(id) < NSEG) begin
      words[int'(id)]  = d;
      loaded[int'(id)] = 1'b1;
    end
    chk("wr_chal", challenge, exp_chal());
    chk("wr_seg", NCHAL'(seg_loaded), NCHAL'(exp_seg()));
  endtask

  // mode 0: plain, 1: write attempt during ARM, 2: chal_en drop at first trig cycle
  task automatic fire(input int mode);
    int lat;
    int w;
    start = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
      if (lat == 1) begin
        chk("arm_busy", NCHAL'(busy), 1);
        chk("arm_ready", NCHAL'(resp_ready), 0);
        chk("arm_tmo", NCHAL'(timeout_err), 0);
      end
      if (mode == 1 && lat == 2) begin wr_en = 1'b1; in_id = 2'd0; data_in = '0; end
      if (mode == 1 && lat == 3) wr_en = 1'b0;
    end while (!trig && lat < 40);
    chk("trig_lat", NCHAL'(lat), NCHAL'(SETTLE + 1));
    chk("fire_chal", challenge, exp_chal());
    if (mode == 2) begin
      chal_en = 1'b0;
      step();
      chk("abort_trig", NCHAL'(trig), 0);
      chk("abort_chal", challenge, 0);
      chk("abort_seg", NCHAL'(seg_loaded), 0);
      chk("abort_busy", NCHAL'(busy), 0);
      chk("abort_ready", NCHAL'(resp_ready), 0);
      chal_en = 1'b1;
      step();
      clear_model();
      return;
    end
    w = 0;
    while (trig && w < 20) begin
      w++;
      step();
    end
    chk("trig_width", NCHAL'(w), NCHAL'(TRIGW));
    chk("wait_busy", NCHAL'(busy), 1);
  endtask

  task automatic respond(input int d, input bit b, input bit tmo);
    int n;
    if (!tmo) begin
      repeat (d) begin
        resp_bit_in = 1'($urandom);
        step();
      end
      resp_valid_in = 1'b1;
      resp_bit_in   = b;
      step();
      resp_valid_in = 1'b0;
      resp_bit_in   = ~b;
    end else begin
      n = 0;
      while (!resp_ready && n < 1100) begin
        resp_bit_in = 1'($urandom);
        step();
        n++;
      end
      chk("tmo_cycles", NCHAL'(n), NCHAL'(TMO));
    end
    chk("resp_ready", NCHAL'(resp_ready), 1);
    chk("resp_bit", NCHAL'(resp_bit), tmo ? 0 : NCHAL'(b));
    chk("resp_tmo", NCHAL'(timeout_err), NCHAL'(tmo));
    chk("done_busy", NCHAL'(busy), 0);
  endtask

  initial begin
    logic [63:0] rw;
    bit tseen;
    bit bseen;
    n_cmp = 0;
    n_err = 0;
    clear_model();
    rst_n = 1'b0; chal_en = 1'b1; wr_en = 1'b0; in_id = '0; data_in = '0;
    start = 1'b0; resp_valid_in = 1'b0; resp_bit_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("rst_chal", challenge, 0);
    chk("rst_seg", NCHAL'(seg_loaded), 0);
    chk("rst_trig", NCHAL'(trig), 0);
    chk("rst_ready", NCHAL'(resp_ready), 0);
    chk("rst_bit", NCHAL'(resp_bit), 0);
    chk("rst_busy", NCHAL'(busy), 0);
    chk("rst_tmo", NCHAL'(timeout_err), 0);

    // response strobe outside WAIT
    resp_valid_in = 1'b1; resp_bit_in = 1'b1;
    step(); step();
    resp_valid_in = 1'b0; resp_bit_in = 1'b0;
    chk("idle_resp_ready", NCHAL'(resp_ready), 0);
    chk("idle_resp_bit", NCHAL'(resp_bit), 0);

    // load and fire, start held through completion
    do_write(2'd0, 64'hF0F0_F0F0_F0F0_F0F0);
    do_write(2'd1, 64'h0123_4567_89AB_CDEF);
    chk("t1_chal", challenge, 128'hF0F0_F0F0_F0F0_F0F0_0123_4567_89AB_CDEF);
    fire(0);
    respond(3, 1'b1, 1'b0);
    step(); step(); step();
    chk("held_start_busy", NCHAL'(busy), 0);
    chk("held_start_ready", NCHAL'(resp_ready), 1);
    start = 1'b0; step();

    // write during ARM is dropped, then re-trigger from DONE
    fire(1);
    respond(2, 1'b0, 1'b0);
    chk("arm_write_chal", challenge, exp_chal());
    start = 1'b0; step();
    fire(0);
    respond(5, 1'b1, 1'b0);
    start = 1'b0; step();

    // timeout
    fire(0);
    respond(0, 1'b0, 1'b1);
    start = 1'b0; step();

    // random writes (including out-of-range ids) and measurements from DONE
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        rw = {$urandom, $urandom};
        do_write(2'($urandom_range(0, 3)), rw);
      end
      fire(0);
      respond(int'($urandom_range(0, 20)), 1'($urandom), 1'b0);
      start = 1'b0; step();
    end

    // chal_en drop during FIRE
    fire(2);
    start = 1'b0; step();

    // partial load cannot start; out-of-range ids change nothing
    rw = {$urandom, $urandom};
    do_write(2'd1, rw);
    rw = {$urandom, $urandom};
    do_write(2'd3, rw);
    rw = {$urandom, $urandom};
    do_write(2'd2, rw);
    start = 1'b1;
    tseen = 1'b0; bseen = 1'b0;
    repeat (15) begin
      step();
      tseen |= trig;
      bseen |= busy;
    end
    chk("partial_trig", NCHAL'(tseen), 0);
    chk("partial_busy", NCHAL'(bseen), 0);
    start = 1'b0; step();

    // async reset in WAIT with wr_en held across release
    rw = {$urandom, $urandom};
    do_write(2'd0, rw);
    fire(0);
    wr_en = 1'b1; in_id = 2'd0; data_in = {$urandom, $urandom};
    step(); step();
    chk("wait_write_chal", challenge, exp_chal());
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_chal", challenge, 0);
    chk("arst_seg", NCHAL'(seg_loaded), 0);
    chk("arst_trig", NCHAL'(trig), 0);
    chk("arst_busy", NCHAL'(busy), 0);
    chk("arst_ready", NCHAL'(resp_ready), 0);
    chk("arst_bit", NCHAL'(resp_bit), 0);
    chk("arst_tmo", NCHAL'(timeout_err), 0);
    start = 1'b0;
    step(); step();
    rst_n = 1'b1;
    clear_model();
    repeat (4) step();
    chk("held_wr_seg", NCHAL'(seg_loaded), NCHAL'(exp_seg()));
    chk("held_wr_chal", challenge, exp_chal());
    wr_en = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
